// File: rtl/auc_loader.sv
// Operand loader: gathers host beats into DEPTH words, then bursts them to the AUC decoder.
// Host strobes are fire-and-forget; beats/commands offered while ldr_rdy is low are dropped and flagged on ldr_err.
module auc_loader #(
  parameter int WIDTH = 256,
  parameter int BUSW  = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_wen,
  input  logic [BUSW-1:0]  host_wdat,
  input  logic             host_cmd,
  input  logic [2:0]       host_mode,
  input  logic [2:0]       host_nwords,
  input  logic             eng_done,
  output logic [WIDTH-1:0] auc_dat,
  output logic             auc_start,
  output logic [2:0]       auc_mode,
  output logic             ldr_rdy,
  output logic             ldr_err,
  output logic [1:0]       dbg_state
);

  localparam int SLICES = WIDTH / BUSW;
  localparam int NBEATS = DEPTH * SLICES;
  localparam int CNT_W  = $clog2(NBEATS + 1);
  localparam int WIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SIDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   buf_q [DEPTH];
  logic [WIDTH-1:0]   buf_d [DEPTH];
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [2:0]         len_q, len_d;
  logic [2:0]         idx_q, idx_d;
  logic               gap_q, gap_d;
  logic [WIDTH-1:0]   dat_q, dat_d;
  logic               start_q, start_d;
  logic [2:0]         mode_q, mode_d;
  logic               err_q, err_d;
  logic               rdy_q, rdy_d;

  logic [WIDX_W-1:0]  word_idx;
  logic [SIDX_W-1:0]  slice_idx;
  logic               cmd_ok;

  assign word_idx  = WIDX_W'(beat_cnt_q / CNT_W'(SLICES));
  assign slice_idx = SIDX_W'(beat_cnt_q % CNT_W'(SLICES));
  assign cmd_ok    = (int'(host_nwords) <= DEPTH) &&
                     (int'(beat_cnt_q) == SLICES * int'(host_nwords));

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    dat_d      = dat_q;
    start_d    = 1'b0;
    mode_d     = mode_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (host_cmd) begin
          // A beat arriving with the command is lost; the command sees the old count.
          if (host_wen) err_d = 1'b1;
          if (cmd_ok) begin
            mode_d  = host_mode;
            len_d   = (host_nwords == 3'd0) ? 3'd1 : host_nwords;
            idx_d   = 3'd1;
            start_d = 1'b1;
            dat_d   = (host_nwords == 3'd0) ? '0 : buf_q[0];
            state_d = S_SEND;
          end else begin
            err_d      = 1'b1;
            buf_d      = '{default: '0};
            beat_cnt_d = '0;
          end
        end else if (host_wen) begin
          if (beat_cnt_q == CNT_W'(NBEATS)) begin
            err_d = 1'b1;
          end else begin
            buf_d[word_idx][slice_idx*BUSW +: BUSW] = host_wdat;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      S_SEND: begin
        if (idx_q == len_q) begin
          state_d = S_GAP;
          gap_d   = 1'b0;
        end else begin
          start_d = 1'b1;
          dat_d   = buf_q[WIDX_W'(idx_q)];
          idx_d   = idx_q + 3'd1;
        end
      end
      S_GAP: begin
        if (gap_q) state_d = S_WAIT;
        else       gap_d   = 1'b1;
      end
      S_WAIT: begin
        if (eng_done) begin
          state_d    = S_IDLE;
          buf_d      = '{default: '0};
          beat_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && (host_wen || host_cmd)) err_d = 1'b1;
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      buf_q      <= '{default: '0};
      beat_cnt_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      gap_q      <= 1'b0;
      dat_q      <= '0;
      start_q    <= 1'b0;
      mode_q     <= 3'b000;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      dat_q      <= dat_d;
      start_q    <= start_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
    end
  end

  assign auc_dat   = dat_q;
  assign auc_start = start_q;
  assign auc_mode  = mode_q;
  assign ldr_rdy   = rdy_q;
  assign ldr_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_auc_loader.sv
// Directed bench for auc_loader: command table in a loop plus hand sequences for reset and error cases.
module tb_auc_loader;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  logic         clk = 1'b0;
  logic         rst;
  logic         host_wen;
  logic [31:0]  host_wdat;
  logic         host_cmd;
  logic [2:0]   host_mode;
  logic [2:0]   host_nwords;
  logic         eng_done;
  logic [255:0] auc_dat;
  logic         auc_start;
  logic [2:0]   auc_mode;
  logic         ldr_rdy;
  logic         ldr_err;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;

  auc_loader dut (
    .clk(clk), .rst(rst), .host_wen(host_wen), .host_wdat(host_wdat),
    .host_cmd(host_cmd), .host_mode(host_mode), .host_nwords(host_nwords),
    .eng_done(eng_done), .auc_dat(auc_dat), .auc_start(auc_start),
    .auc_mode(auc_mode), .ldr_rdy(ldr_rdy), .ldr_err(ldr_err), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    int          nbeats;
    logic [2:0]  mode;
    logic [2:0]  nwords;
    bit          accept;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] exp_word(input logic [31:0] base, input int k);
    logic [255:0] w;
    for (int j = 0; j < 8; j++) w[j*32 +: 32] = base + 32'(8*k + j);
    return w;
  endfunction

  task automatic drive_beats(input int n, input logic [31:0] base);
    logic seen_err;
    seen_err = 1'b0;
    for (int b = 0; b < n; b++) begin
      host_wen  = 1'b1;
      host_wdat = base + 32'(b);
      tick();
      seen_err |= ldr_err;
    end
    host_wen = 1'b0;
    if (n > 0) chk("beat_load_no_err", seen_err, 1'b0);
  endtask

  task automatic issue_cmd(input logic [2:0] mode, input logic [2:0] nw);
    host_cmd    = 1'b1;
    host_mode   = mode;
    host_nwords = nw;
    tick();
    host_cmd = 1'b0;
  endtask

  // Checks from the first SEND cycle through eng_done and return to IDLE.
  task automatic check_burst(input int len, input logic [2:0] nw, input logic [2:0] mode,
                             input logic [31:0] base);
    logic [255:0] last;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("send%0d_start", i), auc_start, 1'b1);
      chk($sformatf("send%0d_dat", i), auc_dat, (nw == 3'd0) ? 256'd0 : exp_word(base, i));
      chk($sformatf("send%0d_mode", i), auc_mode, mode);
      chk($sformatf("send%0d_state", i), dbg_state, ST_SEND);
      chk($sformatf("send%0d_rdy", i), ldr_rdy, 1'b0);
      tick();
    end
    last = (nw == 3'd0) ? 256'd0 : exp_word(base, len - 1);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("gap%0d_start", g), auc_start, 1'b0);
      chk($sformatf("gap%0d_state", g), dbg_state, ST_GAP);
      chk($sformatf("gap%0d_dat_hold", g), auc_dat, last);
      tick();
    end
    chk("wait_state", dbg_state, ST_WAIT);
    chk("wait_mode", auc_mode, mode);
    tick();
    tick();
    chk("wait_rdy_low", ldr_rdy, 1'b0);
    chk("wait_start_low", auc_start, 1'b0);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("done_rdy", ldr_rdy, 1'b1);
    chk("done_state", dbg_state, ST_IDLE);
    chk("done_no_err", ldr_err, 1'b0);
  endtask

  // An empty-buffer command is accepted only when beat_cnt is zero.
  task automatic verify_empty();
    issue_cmd(3'b000, 3'd0);
    chk("empty_cmd_err", ldr_err, 1'b0);
    check_burst(1, 3'd0, 3'b000, 32'd0);
  endtask

  initial begin
    logic [31:0] base;
    int len;

    vecs[0] = '{nbeats: 32, mode: 3'b101, nwords: 3'd4, accept: 1'b1};
    vecs[1] = '{nbeats: 0,  mode: 3'b000, nwords: 3'd0, accept: 1'b1};
    vecs[2] = '{nbeats: 12, mode: 3'b101, nwords: 3'd4, accept: 1'b0};
    vecs[3] = '{nbeats: 8,  mode: 3'b001, nwords: 3'd1, accept: 1'b1};
    vecs[4] = '{nbeats: 16, mode: 3'b111, nwords: 3'd2, accept: 1'b1};
    vecs[5] = '{nbeats: 24, mode: 3'b010, nwords: 3'd3, accept: 1'b1};
    vecs[6] = '{nbeats: 8,  mode: 3'b000, nwords: 3'd0, accept: 1'b0};
    vecs[7] = '{nbeats: 0,  mode: 3'b001, nwords: 3'd5, accept: 1'b0};
    vecs[8] = '{nbeats: 32, mode: 3'b101, nwords: 3'd7, accept: 1'b0};

    rst = 1'b0; host_wen = 1'b0; host_wdat = '0; host_cmd = 1'b0;
    host_mode = '0; host_nwords = '0; eng_done = 1'b0;

    // reset state
    #3;
    chk("rst_dat", auc_dat, 256'd0);
    chk("rst_start", auc_start, 1'b0);
    chk("rst_mode", auc_mode, 3'b000);
    chk("rst_err", ldr_err, 1'b0);
    chk("rst_rdy", ldr_rdy, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_rdy_before_edge", ldr_rdy, 1'b0);
    tick();
    chk("rel_rdy_first_edge", ldr_rdy, 1'b1);

    // command table
    for (int v = 0; v < 9; v++) begin
      base = (v == 0) ? 32'h0000_00A0 : 32'h1000 * 32'(v + 1) + 32'hA0;
      drive_beats(vecs[v].nbeats, base);
      issue_cmd(vecs[v].mode, vecs[v].nwords);
      chk($sformatf("v%0d_cmd_err", v), ldr_err, !vecs[v].accept);
      if (vecs[v].accept) begin
        len = (vecs[v].nwords == 3'd0) ? 1 : int'(vecs[v].nwords);
        check_burst(len, vecs[v].nwords, vecs[v].mode, base);
      end else begin
        chk($sformatf("v%0d_rej_start", v), auc_start, 1'b0);
        chk($sformatf("v%0d_rej_rdy", v), ldr_rdy, 1'b1);
        chk($sformatf("v%0d_rej_state", v), dbg_state, ST_IDLE);
        tick();
        chk($sformatf("v%0d_rej_err_pulse", v), ldr_err, 1'b0);
        verify_empty();
      end
    end

    // 33rd beat overflows and is dropped
    base = 32'h5500_00A0;
    drive_beats(32, base);
    host_wen = 1'b1; host_wdat = 32'hFFFF_FFFF;
    tick();
    host_wen = 1'b0;
    chk("ovf_err", ldr_err, 1'b1);
    tick();
    chk("ovf_err_pulse", ldr_err, 1'b0);
    issue_cmd(3'b101, 3'd4);
    chk("ovf_cmd_err", ldr_err, 1'b0);
    check_burst(4, 3'd4, 3'b101, base);

    // beat and command in the same cycle
    base = 32'h6600_00A0;
    drive_beats(8, base);
    host_wen = 1'b1; host_wdat = 32'hDEAD_BEEF;
    issue_cmd(3'b001, 3'd1);
    host_wen = 1'b0;
    chk("both_err", ldr_err, 1'b1);
    check_burst(1, 3'd1, 3'b001, base);

    // reset during the third SEND cycle
    base = 32'h7700_00A0;
    drive_beats(32, base);
    issue_cmd(3'b101, 3'd4);
    tick();
    tick();
    chk("mid_send3_start", auc_start, 1'b1);
    chk("mid_send3_dat", auc_dat, exp_word(base, 2));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_start", auc_start, 1'b0);
    chk("mid_rst_dat", auc_dat, 256'd0);
    chk("mid_rst_mode", auc_mode, 3'b000);
    chk("mid_rst_rdy", ldr_rdy, 1'b0);
    chk("mid_rst_state", dbg_state, ST_IDLE);
    tick();
    #2 rst = 1'b1;
    tick();
    chk("post_rst_rdy", ldr_rdy, 1'b1);
    tick();
    chk("post_rst_no_resume", auc_start, 1'b0);
    verify_empty();

    // strobes in WAIT, eng_done in IDLE
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("idle_done_no_err", ldr_err, 1'b0);
    chk("idle_done_state", dbg_state, ST_IDLE);
    issue_cmd(3'b000, 3'd0);
    tick();
    tick();
    tick();
    chk("reach_wait", dbg_state, ST_WAIT);
    issue_cmd(3'b101, 3'd0);
    chk("wait_cmd_err", ldr_err, 1'b1);
    chk("wait_cmd_state", dbg_state, ST_WAIT);
    chk("wait_cmd_mode", auc_mode, 3'b000);
    tick();
    chk("wait_cmd_err_pulse", ldr_err, 1'b0);
    host_wen = 1'b1; host_wdat = 32'h1234_5678;
    tick();
    host_wen = 1'b0;
    chk("wait_wen_err", ldr_err, 1'b1);
    chk("wait_wen_state", dbg_state, ST_WAIT);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("wait_exit_state", dbg_state, ST_IDLE);
    chk("wait_exit_rdy", ldr_rdy, 1'b1);
    verify_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/auc_loader.md
AUC_LOADER -- requirements
Module: auc_loader

Interface
REQ-001 Parameters SHALL be WIDTH, default 256, the operand word width, and BUSW, default 32, the host beat width.
REQ-002 Parameter DEPTH SHALL default to 4 and set the maximum number of operand words buffered per command.
REQ-003 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide, asynchronous and active-low; it clears all state when low.
REQ-005 Port host_wen SHALL be an input, 1 bit wide, that strobes one operand beat for one cycle.
REQ-006 Port host_wdat SHALL be an input, BUSW bits wide, carrying the beat data.
REQ-007 Port host_cmd SHALL be an input, 1 bit wide, that strobes a command for one cycle.
REQ-008 Port host_mode SHALL be an input, 3 bits wide, carrying the command mode (000 RAND, 001 INVS, 101 MMUL).
REQ-009 Port host_nwords SHALL be an input, 3 bits wide, giving the operand word count (0..DEPTH) for the command.
REQ-010 Port eng_done SHALL be an input, 1 bit wide: a one-cycle pulse from the crypto engine that ends the current operation.
REQ-011 Port auc_dat SHALL be an output, WIDTH bits wide and registered, carrying operand words to the decoder.
REQ-012 Port auc_start SHALL be an output, 1 bit wide and registered, acting as the burst strobe to the decoder.
REQ-013 Port auc_mode SHALL be an output, 3 bits wide and registered, carrying the mode to the decoder.
REQ-014 Port ldr_rdy SHALL be an output, 1 bit wide, high only in IDLE.
REQ-015 Port ldr_err SHALL be an output, 1 bit wide: a one-cycle error pulse.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, GAP, WAIT; reset state IDLE.
REQ-017 IDLE, host_wen, beat count < DEPTH*WIDTH/BUSW: beat SHALL be stored at word beat_cnt/8, slice beat_cnt%8 (slice 0 = bits 31:0), beat_cnt increments.
REQ-018 IDLE, host_wen with buffer full (32 beats): beat SHALL be dropped, ldr_err pulsed next cycle, beat_cnt unchanged.
REQ-019 IDLE, host_cmd: accepted iff host_nwords <= DEPTH and beat_cnt == 8*host_nwords; otherwise ldr_err pulsed, buffer cleared, stay IDLE.
REQ-020 Accepted command SHALL latch host_mode into auc_mode and burst length L = max(host_nwords,1), then enter SEND.
REQ-021 host_wen and host_cmd in same IDLE cycle: command SHALL take priority using prior beat_cnt; beat dropped, ldr_err pulsed.
REQ-022 SEND: auc_start SHALL be 1 for exactly L consecutive cycles, beginning the cycle after command acceptance.
REQ-023 SEND cycle i (0..L-1): auc_dat SHALL equal buffered word i; if host_nwords = 0, auc_dat = 0.
REQ-024 After the last SEND cycle: auc_start SHALL drop to 0 and the FSM SHALL enter GAP for exactly 2 cycles, then WAIT.
REQ-025 auc_mode SHALL hold stable from the first SEND cycle through WAIT exit; auc_dat SHALL hold its last word outside SEND.
REQ-026 WAIT: FSM SHALL return to IDLE the cycle after eng_done; buffer and beat_cnt cleared on that transition.
REQ-027 host_wen/host_cmd outside IDLE SHALL be ignored and pulse ldr_err; eng_done outside WAIT SHALL be ignored silently.
REQ-028 ldr_rdy SHALL be 1 in IDLE, 0 otherwise; it SHALL be a registered state decode.
REQ-029 Modes other than 000/001/101 SHALL be forwarded unchanged (decoder discards them).

Reset
REQ-030 rst low SHALL asynchronously force auc_dat=0, auc_start=0, auc_mode=000, ldr_err=0, ldr_rdy=0, state IDLE, beat_cnt=0.
REQ-031 ldr_rdy SHALL rise on the first clock edge after rst deasserts.
REQ-032 Reset mid-SEND SHALL drop auc_start immediately; no partial burst resumes after reset release.
REQ-033 Buffer contents SHALL be cleared by reset.

Verification
REQ-034 32 beats (word k, slice j = 32'hA0+8k+j), cmd MMUL nwords=4 -> auc_start high 4 cycles, auc_dat words 0..3 in order, auc_mode=101, then 2 low cycles.
REQ-035 cmd RAND nwords=0 with empty buffer -> auc_start high exactly 1 cycle, auc_dat=0, ldr_rdy low until the cycle after eng_done.
REQ-036 12 beats, cmd MMUL nwords=4 -> ldr_err 1 pulse, no auc_start, beat_cnt=0, ldr_rdy stays 1.
REQ-037 33 beats -> ldr_err on the 33rd beat; later cmd nwords=4 bursts words built from the first 32 beats.
REQ-038 rst low during the 3rd SEND cycle -> auc_start=0 asynchronously; after release ldr_rdy=1, buffer empty.
REQ-039 host_cmd while in WAIT -> ldr_err pulse, state unchanged; eng_done -> IDLE next cycle.
